// File: rtl/imm_encoder_pkg.sv
// Shared RV32I immediate-format codes and the encoder FSM state type.
// Also used by the decode-stage extractor and the control decoder.
package imm_encoder_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] LAST_BEAT = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } enc_state_t;

    // True when every bit of v from position msb down to lsb equals v[msb].
    function automatic logic all_same(input logic [31:0] v, input int msb, input int lsb);
        logic same;
        same = 1'b1;
        for (int i = lsb; i < msb; i++) begin
            if (v[i] != v[msb]) same = 1'b0;
        end
        return same;
    endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational immediate packer: range-checks an immediate for the selected
// RV32I format and scatters it into a base instruction word.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [31:0] base,
    input  logic [2:0]  src,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    // NOTE: every output gets a default before the case, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        word  = base;
        legal = 1'b0;
        case (src)
            IMM_I: begin
                legal       = all_same(imm, 31, 11);
                word[31:20] = imm[11:0];
            end
            IMM_S: begin
                legal       = all_same(imm, 31, 11);
                word[31:25] = imm[11:5];
                word[11:7]  = imm[4:0];
            end
            IMM_B: begin
                legal       = all_same(imm, 31, 12) && !imm[0];
                word[31]    = imm[12];
                word[30:25] = imm[10:5];
                word[11:8]  = imm[4:1];
                word[7]     = imm[11];
            end
            IMM_J: begin
                legal       = all_same(imm, 31, 20) && !imm[0];
                word[31]    = imm[20];
                word[30:21] = imm[10:1];
                word[20]    = imm[11];
                word[19:12] = imm[19:12];
            end
            IMM_U: begin
                legal       = (imm[11:0] == 12'h000);
                word[31:12] = imm[31:12];
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: accepts (base, format, immediate), packs the instruction
// and streams it out as four little-endian bytes over a valid/ready port.
module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_base,
    input  logic [2:0]  in_src,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        err
);

    enc_state_t  state_q, state_d;
    logic [1:0]  beat_q, beat_d, beat_next;
    logic [31:0] word_q, word_d;
    logic        out_valid_d, out_last_d, err_d;
    logic [7:0]  out_data_d;

    logic [31:0] pack_word;
    logic        pack_legal;
    logic        take, hs;

    imm_pack u_pack (
        .base  (in_base),
        .src   (in_src),
        .imm   (in_imm),
        .word  (pack_word),
        .legal (pack_legal)
    );

    assign in_ready  = (state_q == IDLE);
    assign take      = in_valid && in_ready;
    assign hs        = out_valid && out_ready;
    assign beat_next = beat_q + 2'd1;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    // The word register is reset too, keeping out_data deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            beat_q    <= 2'd0;
            word_q    <= 32'h0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            word_q    <= word_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_last  <= out_last_d;
            err       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take && pack_legal) state_d = SEND;
            SEND:    if (hs && beat_q == LAST_BEAT) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered output values; everything holds unless a transfer or a
    // byte handshake moves it.
    always_comb begin
        beat_d      = beat_q;
        word_d      = word_q;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_last_d  = out_last;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (take) begin
                    if (pack_legal) begin
                        word_d      = pack_word;
                        beat_d      = 2'd0;
                        out_valid_d = 1'b1;
                        out_data_d  = pack_word[7:0];
                        out_last_d  = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (hs) begin
                    if (beat_q == LAST_BEAT) begin
                        out_valid_d = 1'b0;
                        out_data_d  = 8'h00;
                        out_last_d  = 1'b0;
                    end else begin
                        beat_d     = beat_next;
                        out_data_d = word_q[{beat_next, 3'b000} +: 8];
                        out_last_d = (beat_next == LAST_BEAT);
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: byte streams, range rejects, backpressure,
// asynchronous abort and a round-trip through a reference immediate extractor.
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_base = '0;
    logic [2:0]  in_src = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_last;
    logic        err;

    int n_checks = 0;
    int n_fail = 0;

    imm_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_base   (in_base),
        .in_src    (in_src),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request for a single cycle; returns at the negedge after
    // the accepting edge.
    task automatic request(input logic [31:0] base, input logic [2:0] src, input logic [31:0] imm);
        @(negedge clk);
        check("req_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_base  = base;
        in_src   = src;
        in_imm   = imm;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Collect four bytes with out_ready high, checking the exact cadence.
    task automatic collect(input string tag, output logic [31:0] w);
        w = '0;
        for (int b = 0; b < 4; b++) begin
            check({tag, "_valid"}, out_valid, 1'b1);
            check({tag, "_busy"}, in_ready, 1'b0);
            check({tag, "_last"}, out_last, (b == 3));
            check({tag, "_err"}, err, 1'b0);
            w[8*b +: 8] = out_data;
            @(negedge clk);
        end
        check({tag, "_done_valid"}, out_valid, 1'b0);
        check({tag, "_done_ready"}, in_ready, 1'b1);
    endtask

    task automatic expect_reject(input string tag);
        check({tag, "_err"}, err, 1'b1);
        check({tag, "_novalid"}, out_valid, 1'b0);
        check({tag, "_ready"}, in_ready, 1'b1);
        @(negedge clk);
        check({tag, "_err_clr"}, err, 1'b0);
        check({tag, "_novalid2"}, out_valid, 1'b0);
    endtask

    // Reference decode-stage immediate extractor.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] src);
        case (src)
            IMM_I:   return {{20{w[31]}}, w[31:20]};
            IMM_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
            IMM_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            IMM_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return {w[31:12], 12'h000};
        endcase
    endfunction

    initial begin
        logic [31:0] w, r, imm, held;
        logic [2:0]  src;

        // Reset state
        #2;
        check("rst_valid", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_data", out_data, 8'h00);
        check("rst_last", out_last, 1'b0);
        check("rst_err", err, 1'b0);
        #10 rst_n = 1'b1;

        // I, sign-extended -1
        request(32'h0000_0093, IMM_I, 32'hFFFF_FFFF);
        collect("i_neg1", w);
        check("i_neg1_word", w, 32'hFFF0_0093);

        // B, offset 8, then misaligned offset 7
        request(32'h0000_0063, IMM_B, 32'd8);
        collect("b_8", w);
        check("b_8_word", w, 32'h0000_0463);
        request(32'h0000_0063, IMM_B, 32'd7);
        expect_reject("b_7");

        // J, offset -4
        request(32'h0000_006F, IMM_J, 32'hFFFF_FFFC);
        collect("j_m4", w);
        check("j_m4_word", w, 32'hFFDF_F06F);

        // U legal and range rejects
        request(32'h0000_02B7, IMM_U, 32'h1234_5000);
        collect("u_ok", w);
        check("u_ok_word", w, 32'h1234_52B7);
        request(32'h0000_02B7, IMM_U, 32'h1234_5001);
        expect_reject("u_low");
        request(32'h0000_0093, IMM_I, 32'd2048);
        expect_reject("i_2048");
        request(32'h0000_0093, IMM_I, 32'hFFFF_F800);
        collect("i_m2048", w);
        check("i_m2048_word", w, 32'h8000_0093);
        request(32'h0000_0093, 3'b101, 32'd0);
        expect_reject("src_101");

        // S, offset -1 and back-to-back request during the err cycle
        request(32'h0000_0023, 3'b111, 32'd0);
        check("b2b_err", err, 1'b1);
        check("b2b_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_base  = 32'h0000_0023;
        in_src   = IMM_S;
        in_imm   = 32'hFFFF_FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        collect("s_b2b", w);
        check("s_b2b_word", w, 32'hFE00_0FA3);

        // Backpressure on byte 1
        request(32'h0000_02B7, IMM_U, 32'hA1B2_C000);
        check("bp_b0", out_data, 8'hB7);
        @(negedge clk);
        check("bp_b1", out_data, 8'hC2);
        held = {24'h0, out_data};
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_hold_data", {24'h0, out_data}, held);
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_ready", in_ready, 1'b0);
            check("bp_hold_last", out_last, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_b2", out_data, 8'hB2);
        @(negedge clk);
        check("bp_b3", out_data, 8'hA1);
        check("bp_b3_last", out_last, 1'b1);
        @(negedge clk);
        check("bp_done", out_valid, 1'b0);

        // Asynchronous reset during byte 2
        request(32'h0000_0093, IMM_I, 32'h0000_0123);
        @(negedge clk);
        @(negedge clk);
        check("ab_b2_valid", out_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("ab_valid", out_valid, 1'b0);
        check("ab_ready", in_ready, 1'b1);
        check("ab_data", out_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        request(32'h0000_0093, IMM_I, 32'h0000_0123);
        collect("ab_again", w);
        check("ab_again_word", w, 32'h1230_0093);

        // Round-trip through the reference extractor
        for (int k = 0; k < 10; k++) begin
            r   = $urandom;
            src = 3'($urandom_range(0, 4));
            case (src)
                IMM_I, IMM_S: imm = {{20{r[11]}}, r[11:0]};
                IMM_B:        imm = {{19{r[12]}}, r[12:1], 1'b0};
                IMM_J:        imm = {{11{r[20]}}, r[20:1], 1'b0};
                default:      imm = {r[31:12], 12'h000};
            endcase
            request(32'h0000_0013, src, imm);
            collect("rt", w);
            check("rt_imm", extract(w, src), imm);
            check("rt_opcode", {25'h0, w[6:0]}, 32'h13);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
